// File: rtl/usb_bus_bridge.sv
// Bridges the SoC CPU memory bus to the ISP1760 asynchronous 16-bit bus and sequences the USB chip reset.
// Optional build macro USB_IRQ_SYNC_EN: synchronises usb_irq onto usb_int; otherwise usb_int is tied low.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a command; mem_cmd_ready may be high
// ST_SETUP   | cs_ low, address (and write data) valid ahead of the strobe
// ST_STROBE  | rd_ or wr_ low; read data captured on the last cycle
// ST_HOLD    | strobe released, cs_ still low, data held
// ST_RECOVER | cs_ high between halfword cycles

module usb_bus_bridge #(
   parameter int unsigned SETUP_CYCLES    = 1,
   parameter int unsigned STROBE_CYCLES   = 3,
   parameter int unsigned HOLD_CYCLES     = 1,
   parameter int unsigned RECOVERY_CYCLES = 2,
   parameter int unsigned RESET_CYCLES    = 1024
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        mem_cmd_sel,
   input  logic        mem_cmd_valid,
   output logic        mem_cmd_ready,
   input  logic        mem_cmd_wr,
   input  logic [17:0] mem_cmd_addr,
   input  logic [31:0] mem_cmd_wdata,
   input  logic [3:0]  mem_cmd_be,
   output logic        mem_rsp_ready,
   output logic [31:0] mem_rsp_rdata,
   output logic        usb_reset_,
   output logic        usb_cs_,
   output logic        usb_rd_,
   output logic        usb_wr_,
   output logic [16:0] usb_a,
   output logic        usb_d_oe,
   output logic [15:0] usb_d_do,
   input  logic [15:0] usb_d_di,
   input  logic        usb_irq,
   output logic        usb_int
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   localparam logic [3:0]  SETUP_LD   = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0]  STROBE_LD  = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0]  HOLD_LD    = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0]  RECOVER_LD = 4'(RECOVERY_CYCLES - 1);
   localparam logic [15:0] RESET_LD   = 16'(RESET_CYCLES);

   state_t      state_q;
   state_t      state_nxt;
   logic [3:0]  tmr_q;
   logic        tmr_done;

   logic [15:0] rst_cnt_q;
   logic        usb_reset_q;

   logic        ready_q;
   logic        rsp_q;
   logic [31:0] rdata_q;
   logic        wr_q;
   logic [15:0] addr_q;
   logic [31:0] wdata_q;
   logic        cur_hi_q;
   logic        hi_pend_q;

   logic        accept;
   logic        need_lo;
   logic        need_hi;
   logic        in_cycle;

   assign accept   = mem_cmd_valid & mem_cmd_sel & ready_q;
   assign need_lo  = ~mem_cmd_wr | (|mem_cmd_be[1:0]);
   assign need_hi  = ~mem_cmd_wr | (|mem_cmd_be[3:2]);
   assign tmr_done = (tmr_q == 4'd0);

   // chip reset: usb_reset_ rises after RESET_CYCLES cycles with reset_ released
   always_ff @(posedge clk) begin
      if (!reset_) begin
         rst_cnt_q   <= RESET_LD;
         usb_reset_q <= 1'b0;
      end else begin
         if (rst_cnt_q != 16'd0)
            rst_cnt_q <= rst_cnt_q - 16'd1;
         if (rst_cnt_q == 16'd1)
            usb_reset_q <= 1'b1;
      end
   end

   // state register and phase timer
   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q <= ST_IDLE;
         tmr_q   <= 4'd0;
      end else begin
         state_q <= state_nxt;
         if (state_nxt != state_q) begin
            unique case (state_nxt)
               ST_SETUP:   tmr_q <= SETUP_LD;
               ST_STROBE:  tmr_q <= STROBE_LD;
               ST_HOLD:    tmr_q <= HOLD_LD;
               ST_RECOVER: tmr_q <= RECOVER_LD;
               default:    tmr_q <= 4'd0;
            endcase
         end else if (!tmr_done) begin
            tmr_q <= tmr_q - 4'd1;
         end
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ST_IDLE:    if (accept && (need_lo || need_hi)) state_nxt = ST_SETUP;
         ST_SETUP:   if (tmr_done) state_nxt = ST_STROBE;
         ST_STROBE:  if (tmr_done) state_nxt = ST_HOLD;
         ST_HOLD:    if (tmr_done) state_nxt = ST_RECOVER;
         ST_RECOVER: if (tmr_done) state_nxt = hi_pend_q ? ST_SETUP : ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // command latch, half sequencing, read capture and response
   always_ff @(posedge clk) begin
      if (!reset_) begin
         ready_q   <= 1'b0;
         rsp_q     <= 1'b0;
         rdata_q   <= 32'd0;
         wr_q      <= 1'b0;
         addr_q    <= 16'd0;
         wdata_q   <= 32'd0;
         cur_hi_q  <= 1'b0;
         hi_pend_q <= 1'b0;
      end else begin
         ready_q <= usb_reset_q && (state_nxt == ST_IDLE);
         rsp_q   <= (state_q == ST_HOLD) && (state_nxt == ST_RECOVER) && cur_hi_q && !wr_q;

         if (accept) begin
            wr_q      <= mem_cmd_wr;
            addr_q    <= mem_cmd_addr[17:2];
            wdata_q   <= mem_cmd_wdata;
            cur_hi_q  <= ~need_lo;
            hi_pend_q <= need_lo & need_hi;
         end else if ((state_q == ST_RECOVER) && tmr_done && hi_pend_q) begin
            cur_hi_q  <= 1'b1;
            hi_pend_q <= 1'b0;
         end

         if ((state_q == ST_STROBE) && tmr_done && !wr_q) begin
            if (cur_hi_q)
               rdata_q[31:16] <= usb_d_di;
            else
               rdata_q[15:0]  <= usb_d_di;
         end
      end
   end

   // bus outputs decoded from registered state only, so strobes never overlap
   always_comb begin
      in_cycle = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
      usb_cs_  = ~in_cycle;
      usb_rd_  = ~((state_q == ST_STROBE) && !wr_q);
      usb_wr_  = ~((state_q == ST_STROBE) && wr_q);
      usb_d_oe = in_cycle && wr_q;
      usb_a    = {addr_q, cur_hi_q};
      usb_d_do = cur_hi_q ? wdata_q[31:16] : wdata_q[15:0];
   end

   assign mem_cmd_ready = ready_q;
   assign mem_rsp_ready = rsp_q;
   assign mem_rsp_rdata = rdata_q;
   assign usb_reset_    = usb_reset_q;

`ifdef USB_IRQ_SYNC_EN
   logic irq_s1_q;
   logic irq_s2_q;
   logic unused_bits;

   always_ff @(posedge clk) begin
      if (!reset_ || !usb_reset_q) begin
         irq_s1_q <= 1'b0;
         irq_s2_q <= 1'b0;
      end else begin
         irq_s1_q <= usb_irq;
         irq_s2_q <= irq_s1_q;
      end
   end

   assign usb_int     = irq_s2_q;
   assign unused_bits = ^mem_cmd_addr[1:0];
`else
   logic unused_bits;

   assign usb_int     = 1'b0;
   assign unused_bits = ^{mem_cmd_addr[1:0], usb_irq};
`endif

endmodule

// File: tb/tb_usb_bus_bridge.sv
// Randomised bench for usb_bus_bridge; expected bus timing is derived arithmetically from the phase lengths.
module tb_usb_bus_bridge;

   localparam int S   = 1;
   localparam int T   = 3;
   localparam int H   = 1;
   localparam int R   = 2;
   localparam int RST = 8;
   localparam int P   = S + T + H + R;

   logic        clk = 1'b0;
   logic        reset_;
   logic        mem_cmd_sel;
   logic        mem_cmd_valid;
   logic        mem_cmd_ready;
   logic        mem_cmd_wr;
   logic [17:0] mem_cmd_addr;
   logic [31:0] mem_cmd_wdata;
   logic [3:0]  mem_cmd_be;
   logic        mem_rsp_ready;
   logic [31:0] mem_rsp_rdata;
   logic        usb_reset_;
   logic        usb_cs_;
   logic        usb_rd_;
   logic        usb_wr_;
   logic [16:0] usb_a;
   logic        usb_d_oe;
   logic [15:0] usb_d_do;
   logic [15:0] usb_d_di;
   logic        usb_irq;
   logic        usb_int;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   usb_bus_bridge #(
      .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H),
      .RECOVERY_CYCLES(R), .RESET_CYCLES(RST)
   ) dut (
      .clk(clk), .reset_(reset_),
      .mem_cmd_sel(mem_cmd_sel), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
      .mem_cmd_be(mem_cmd_be), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
      .usb_reset_(usb_reset_), .usb_cs_(usb_cs_), .usb_rd_(usb_rd_), .usb_wr_(usb_wr_),
      .usb_a(usb_a), .usb_d_oe(usb_d_oe), .usb_d_do(usb_d_do), .usb_d_di(usb_d_di),
      .usb_irq(usb_irq), .usb_int(usb_int)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (mem_cmd_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("ready_timeout", 32'(mem_cmd_ready), 32'd1);
   endtask

   // called at a negedge after reset_ has been sampled low at least once
   task automatic reset_release();
      reset_ = 1'b1;
      for (int i = 1; i <= RST + 1; i++) begin
         @(negedge clk);
         chk("usb_reset_seq", 32'(usb_reset_), 32'(i >= RST));
         chk("ready_after_rst", 32'(mem_cmd_ready), 32'(i >= RST + 1));
         chk("rsp_quiet", 32'(mem_rsp_ready), 32'd0);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_ready", 32'(mem_cmd_ready), 32'd0);
      chk("rst_rsp", 32'(mem_rsp_ready), 32'd0);
      chk("rst_rdata", mem_rsp_rdata, 32'd0);
      chk("rst_usb_reset", 32'(usb_reset_), 32'd0);
      chk("rst_cs", 32'(usb_cs_), 32'd1);
      chk("rst_rd", 32'(usb_rd_), 32'd1);
      chk("rst_wr", 32'(usb_wr_), 32'd1);
      chk("rst_a", 32'(usb_a), 32'd0);
      chk("rst_oe", 32'(usb_d_oe), 32'd0);
      chk("rst_do", 32'(usb_d_do), 32'd0);
      chk("rst_int", 32'(usb_int), 32'd0);
   endtask

   // One CPU access; cycle k counts edges after the accepting edge.
   task automatic run_txn(input logic wr, input logic [17:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [15:0] lo, input logic [15:0] hi,
                          input int abort_k);
      logic hl [2];
      int   n, done, idx, off;
      logic in_cs, stb, half, rsp_exp;
      n = 0;
      hl[0] = 1'b0;
      hl[1] = 1'b1;
      if (!wr || be[1:0] != 2'b00) begin hl[n] = 1'b0; n++; end
      if (!wr || be[3:2] != 2'b00) begin hl[n] = 1'b1; n++; end
      done = 1 + n * P;
      wait_ready();
      mem_cmd_valid = 1'b1;
      mem_cmd_sel   = 1'b1;
      mem_cmd_wr    = wr;
      mem_cmd_addr  = addr;
      mem_cmd_wdata = wd;
      mem_cmd_be    = be;
      @(posedge clk);
      #1;
      mem_cmd_valid = 1'b0;
      mem_cmd_sel   = 1'($urandom);
      mem_cmd_addr  = 18'($urandom);
      mem_cmd_wdata = $urandom;
      mem_cmd_be    = 4'($urandom);
      for (int k = 1; k <= done; k++) begin
         @(negedge clk);
         idx     = (k - 1) / P;
         off     = (k - 1) % P;
         in_cs   = (idx < n) && (off < S + T + H);
         stb     = (idx < n) && (off >= S) && (off < S + T);
         half    = (idx < n) ? hl[idx] : 1'b0;
         rsp_exp = !wr && (idx == 1) && (off == S + T + H);
         chk("cs", 32'(usb_cs_), 32'(!in_cs));
         chk("rd", 32'(usb_rd_), 32'(!(stb && !wr)));
         chk("wr", 32'(usb_wr_), 32'(!(stb && wr)));
         chk("oe", 32'(usb_d_oe), 32'(wr && in_cs));
         if (in_cs) chk("addr", 32'(usb_a), 32'({addr[17:2], half}));
         if (in_cs && wr) chk("dout", 32'(usb_d_do), 32'(half ? wd[31:16] : wd[15:0]));
         chk("rsp", 32'(mem_rsp_ready), 32'(rsp_exp));
         if (rsp_exp) chk("rdata", mem_rsp_rdata, {hi, lo});
         chk("ready", 32'(mem_cmd_ready), 32'(k == done));
         if (k == abort_k) begin
            reset_ = 1'b0;
            return;
         end
         usb_d_di = stb ? (half ? hi : lo) : 16'($urandom);
      end
   endtask

   initial begin
      reset_        = 1'b0;
      mem_cmd_sel   = 1'b0;
      mem_cmd_valid = 1'b0;
      mem_cmd_wr    = 1'b0;
      mem_cmd_addr  = '0;
      mem_cmd_wdata = '0;
      mem_cmd_be    = '0;
      usb_d_di      = '0;
      usb_irq       = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      reset_release();

      run_txn(1'b0, 18'h00304, 32'h0, 4'h0, 16'h1234, 16'hABCD, 0);
      run_txn(1'b1, 18'h00010, 32'hDEADBEEF, 4'hF, 16'h0, 16'h0, 0);
      run_txn(1'b1, 18'h00010, 32'hDEADBEEF, 4'hC, 16'h0, 16'h0, 0);
      run_txn(1'b1, 18'h00020, 32'hCAFEF00D, 4'h0, 16'h0, 16'h0, 0);
      run_txn(1'b1, 18'h3FFFC, 32'h13572468, 4'h1, 16'h0, 16'h0, 0);

      // commands without sel are ignored
      wait_ready();
      mem_cmd_valid = 1'b1;
      mem_cmd_sel   = 1'b0;
      mem_cmd_wr    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("nosel_cs", 32'(usb_cs_), 32'd1);
         chk("nosel_ready", 32'(mem_cmd_ready), 32'd1);
      end
      mem_cmd_valid = 1'b0;

      for (int i = 0; i < 40; i++)
         run_txn(1'($urandom), 18'($urandom), $urandom, 4'($urandom),
                 16'($urandom), 16'($urandom), 0);

      // reset during the high-half strobe of a read
      run_txn(1'b0, 18'h01230, 32'h0, 4'h0, 16'h5555, 16'hAAAA, 9);
      @(negedge clk);
      chk("abort_cs", 32'(usb_cs_), 32'd1);
      chk("abort_rd", 32'(usb_rd_), 32'd1);
      chk("abort_oe", 32'(usb_d_oe), 32'd0);
      chk("abort_usb_reset", 32'(usb_reset_), 32'd0);
      chk("abort_ready", 32'(mem_cmd_ready), 32'd0);
      chk("abort_rsp", 32'(mem_rsp_ready), 32'd0);
      chk("abort_a", 32'(usb_a), 32'd0);
      chk("abort_rdata", mem_rsp_rdata, 32'd0);
      reset_release();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", 32'(mem_rsp_ready), 32'd0);
      end

      run_txn(1'b0, 18'h00304, 32'h0, 4'h0, 16'h0F0F, 16'hF0F0, 0);

      @(negedge clk);
      usb_irq = 1'b1;
`ifdef USB_IRQ_SYNC_EN
      @(negedge clk);
      chk("irq_lat1", 32'(usb_int), 32'd0);
      @(negedge clk);
      chk("irq_lat2", 32'(usb_int), 32'd1);
`else
      repeat (3) @(negedge clk);
      chk("irq_tied", 32'(usb_int), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
